// File: rtl/spi_pkg.sv
// Shared SPI master definitions: command encodings,
// frame widths and the controller state encoding.
package spi_pkg;

    localparam int FRAME_W = 10;
    localparam int DATA_W  = 8;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREFIX,
        ST_SHIFT,
        ST_TURN,
        ST_CAPTURE,
        ST_GAP
    } state_t;

    function automatic logic [FRAME_W-1:0] frame_word(
        input logic [1:0]        t,
        input logic [DATA_W-1:0] d
    );
        return {t, d};
    endfunction

endpackage

// File: rtl/spi_master_shifter.sv
// Datapath for the SPI master: 10-bit PISO feeding mosi, 8-bit SIPO from miso.
// Ports: load/load_word, shift_en, sample_en, count_en, cnt_clr, last_idx,
// miso in; tx_bit (next mosi bit), rx_next (SIPO incl. current miso), done out.
module spi_master_shifter
    import spi_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [FRAME_W-1:0] load_word,
    input  logic               shift_en,
    input  logic               sample_en,
    input  logic               count_en,
    input  logic               cnt_clr,
    input  logic [3:0]         last_idx,
    input  logic               miso,
    output logic               tx_bit,
    output logic [DATA_W-1:0]  rx_next,
    output logic               done
);

    logic [FRAME_W-1:0] tx_q;
    logic [DATA_W-1:0]  rx_q;
    logic [3:0]         cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q <= '0;
            rx_q <= '0;
            cnt  <= '0;
        end else begin
            if (load)
                tx_q <= load_word;
            else if (shift_en)
                tx_q <= {tx_q[FRAME_W-2:0], 1'b0};

            if (sample_en)
                rx_q <= rx_next;

            if (load || cnt_clr)
                cnt <= '0;
            else if (count_en)
                cnt <= cnt + 4'd1;
        end
    end

    assign tx_bit  = tx_q[FRAME_W-1];
    assign rx_next = {rx_q[DATA_W-2:0], miso};
    assign done    = (cnt == last_idx);

endmodule

// File: rtl/spi_master_ctrl.sv
// Host-side SPI master: one RAM command per handshake, serialised as
// prefix + {type,data}; rd-data frames capture a byte from miso.
// Ports: clk, rst_n; cmd_valid/cmd_ready/cmd_type/cmd_data in;
// rsp_valid/rsp_data out; busy; mosi, ss_n out; miso in.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int GAP    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_type,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              mosi,
    output logic              ss_n,
    input  logic              miso
);

    state_t state, state_nx;
    cmd_t   type_q;
    logic [3:0] tmr;
    logic       accept;
    logic       tx_bit;
    logic       sh_done;
    logic [DATA_W-1:0] rx_next;

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    accept   = 1'b1;
                    state_nx = ST_PREFIX;
                end
            end
            ST_PREFIX:
                state_nx = ST_SHIFT;
            ST_SHIFT: begin
                if (sh_done)
                    state_nx = (type_q == CMD_RD_DATA) ?
                               ST_TURN : ST_GAP;
            end
            ST_TURN: begin
                if (tmr == 4'd0)
                    state_nx = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (sh_done)
                    state_nx = ST_GAP;
            end
            ST_GAP: begin
                if (tmr == 4'd0)
                    state_nx = ST_IDLE;
            end
            default:
                state_nx = ST_IDLE;
        endcase
    end

    // Bit counter restarts on every state change so SHIFT
    // and CAPTURE each begin counting from zero.
    spi_master_shifter u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .load_word (frame_word(cmd_type, cmd_data)),
        .shift_en  (state == ST_PREFIX || state == ST_SHIFT),
        .sample_en (state == ST_CAPTURE),
        .count_en  (state == ST_SHIFT || state == ST_CAPTURE),
        .cnt_clr   (state_nx != state),
        .last_idx  ((state == ST_CAPTURE) ? 4'd7 : 4'd9),
        .miso      (miso),
        .tx_bit    (tx_bit),
        .rx_next   (rx_next),
        .done      (sh_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            type_q    <= CMD_WR_ADDR;
            tmr       <= '0;
            ss_n      <= 1'b1;
            mosi      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= state_nx;
            rsp_valid <= 1'b0;

            if (accept)
                type_q <= cmd_t'(cmd_type);

            // One timer serves both TURN and GAP; loaded with
            // length-1 on entry, state exits when it hits zero.
            if (state_nx == ST_TURN && state != ST_TURN)
                tmr <= 4'(RD_LAT - 1);
            else if (state_nx == ST_GAP && state != ST_GAP)
                tmr <= 4'(GAP - 1);
            else if (tmr != 4'd0)
                tmr <= tmr - 4'd1;

            // Pin registers follow the state being entered so
            // they line up with the state they belong to.
            ss_n <= (state_nx == ST_IDLE) || (state_nx == ST_GAP);

            if (state_nx == ST_PREFIX)
                mosi <= cmd_type[1];
            else if (state_nx == ST_SHIFT)
                mosi <= tx_bit;
            else
                mosi <= 1'b0;

            if (state == ST_CAPTURE && sh_done) begin
                rsp_data  <= rx_next;
                rsp_valid <= 1'b1;
            end
        end
    end

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

endmodule
